// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the neuron layers: word/accumulator sizing,
// the sequencer state enum and the round-and-saturate step.
package nn_fixed_pkg;

  localparam int MAX_W     = 32;
  localparam int MAX_ACC_W = 64;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ROUND, DONE} state_t;

  function automatic int word_width(input int int_bits, input int frc_bits);
    return int_bits + frc_bits;
  endfunction

  function automatic int acc_width(input int w, input int num_inputs);
    return 2 * w + $clog2(num_inputs + 1);
  endfunction

  // Callers sign-extend acc to MAX_ACC_W and truncate the result to their word width.
  function automatic logic signed [MAX_W-1:0] sat_round(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          frc_bits,
    input int                          w,
    input logic                        relu
  );
    logic signed [MAX_ACC_W-1:0] one;
    logic signed [MAX_ACC_W-1:0] half;
    logic signed [MAX_ACC_W-1:0] r;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    one  = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
    half = one <<< (frc_bits - 1);
    r    = (acc + half) >>> frc_bits;
    hi   = (one <<< (w - 1)) - one;
    lo   = -(one <<< (w - 1));
    if (r > hi)
      r = hi;
    else if (r < lo)
      r = lo;
    if (relu && r[MAX_ACC_W-1])
      r = '0;
    return r[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Registered signed multiply-accumulate; add_bias folds a in at product scale
// so a bias word lines up with the 2*FRC_BITS fractional point of the products.
module fx_mac
  import nn_fixed_pkg::*;
#(
  parameter int W        = 12,
  parameter int FRC_BITS = 7,
  parameter int ACC_W    = 34
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    add_bias,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = 2 * W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] addend;

  assign prod     = PW'(a) * PW'(b);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'(a) <<< FRC_BITS;
  assign addend   = add_bias ? bias_ext : prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + addend;
  end

endmodule

// File: rtl/neuron_weight_reader.sv
// One output neuron: walks its weight ROM and the activation buffer in lockstep,
// accumulates the dot product plus bias, then hands back a rounded, saturated word.
module neuron_weight_reader
  import nn_fixed_pkg::*;
#(
  parameter int  INT_BITS   = 5,
  parameter int  FRC_BITS   = 7,
  parameter int  NUM_INPUTS = 784,
  parameter int  RELU       = 0,
  localparam int W          = word_width(INT_BITS, FRC_BITS),
  localparam int ACC_W      = acc_width(W, NUM_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic [9:0]          rd_addr,
  input  logic signed [W-1:0] w_data,
  input  logic signed [W-1:0] x_data,
  output logic signed [W-1:0] res_data,
  output logic                res_valid,
  input  logic                res_ready
);

  localparam logic [9:0] BIAS_ADDR = 10'(NUM_INPUTS);

  state_t                  state;
  state_t                  next_state;
  logic [9:0]              addr_next;
  logic                    mac_clr;
  logic                    load_res;
  logic                    tap_valid;
  logic                    tap_bias;
  logic signed [ACC_W-1:0] acc;

  always_comb begin
    next_state = state;
    addr_next  = rd_addr;
    mac_clr    = 1'b0;
    load_res   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = FETCH;
          addr_next  = '0;
          mac_clr    = 1'b1;
        end
      end
      FETCH: begin
        if (rd_addr == BIAS_ADDR) begin
          next_state = DRAIN;
          addr_next  = '0;
        end else begin
          addr_next = rd_addr + 10'd1;
        end
      end
      DRAIN: next_state = ROUND;
      ROUND: begin
        next_state = DONE;
        load_res   = 1'b1;
      end
      DONE: begin
        if (res_ready)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Tap flags trail the address by one cycle to line up with the ROM/buffer read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      tap_valid <= 1'b0;
      tap_bias  <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= next_state;
      rd_addr   <= addr_next;
      tap_valid <= (state == FETCH);
      tap_bias  <= (state == FETCH) && (rd_addr == BIAS_ADDR);
      if (load_res) begin
        res_data  <= W'(sat_round(MAX_ACC_W'(acc), FRC_BITS, W, RELU != 0));
        res_valid <= 1'b1;
      end else if (state == DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

  fx_mac #(
    .W        (W),
    .FRC_BITS (FRC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (tap_valid),
    .add_bias (tap_bias),
    .a        (w_data),
    .b        (x_data),
    .acc      (acc)
  );

endmodule
